// File: rtl/reg_file_if.sv
// Bus bundle for reg_file_param: write port, two read ports, scoreboard and clear control.
interface reg_file_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             Load;
    logic [AW-1:0]    DR;
    logic [WIDTH-1:0] Q;
    logic [AW-1:0]    SR1;
    logic [AW-1:0]    SR2;
    logic [WIDTH-1:0] SR1_OUT;
    logic [WIDTH-1:0] SR2_OUT;
    logic             Mark;
    logic [AW-1:0]    Mark_addr;
    logic             SR1_busy;
    logic             SR2_busy;
    logic             Clear_req;
    logic             Clear_busy;
    logic             Clear_done;

    modport master (
        output Load, DR, Q, SR1, SR2, Mark, Mark_addr, Clear_req,
        input  SR1_OUT, SR2_OUT, SR1_busy, SR2_busy, Clear_busy, Clear_done
    );

    modport slave (
        input  Load, DR, Q, SR1, SR2, Mark, Mark_addr, Clear_req,
        output SR1_OUT, SR2_OUT, SR1_busy, SR2_busy, Clear_busy, Clear_done
    );
endinterface

// File: rtl/reg_file_param.sv
// 2-read/1-write register file with write-to-read bypass, pending-write
// scoreboard and a one-register-per-cycle hardware clear sequencer.
module reg_file_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    reg_file_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [AW-1:0]    idx_r;
    logic [AW-1:0]    idx_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic             clear_busy_r;
    logic             clear_done_r;
    logic             wr_en_s;
    logic             mark_en_s;

    // Non-power-of-two depths leave address codes with no backing register.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({{(32-AW){1'b0}}, a} < 32'(DEPTH));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] d;
        if (!in_range(a)) begin
            d = {WIDTH{1'b0}};
        end else if (bus.Load && (bus.DR == a) && (state_r != ST_CLEAR)) begin
            d = bus.Q;
        end else begin
            d = mem_r[a];
        end
        return d;
    endfunction

    // Qualify write and mark requests; the clear sequencer owns the array while active.
    always_comb begin
        wr_en_s   = 1'b0;
        mark_en_s = 1'b0;
        if (state_r != ST_CLEAR) begin
            wr_en_s   = bus.Load && in_range(bus.DR);
            mark_en_s = bus.Mark && in_range(bus.Mark_addr);
        end else begin
            wr_en_s   = 1'b0;
            mark_en_s = 1'b0;
        end
    end

    // Clear sequencer next-state and index logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.Clear_req) begin
                    state_s = ST_CLEAR;
                    idx_s   = {AW{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (idx_r == AW'(DEPTH - 1)) begin
                    state_s = ST_DONE;
                    idx_s   = {AW{1'b0}};
                end else begin
                    idx_s   = idx_r + AW'(1'b1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state register; status flags are registered from the next state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {AW{1'b0}};
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            clear_busy_r <= (state_s == ST_CLEAR);
            clear_done_r <= (state_s == ST_DONE);
        end
    end

    // Register array: clear sweep takes priority over normal writes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (state_r == ST_CLEAR) begin
            mem_r[idx_r] <= {WIDTH{1'b0}};
        end else if (wr_en_s) begin
            mem_r[bus.DR] <= bus.Q;
        end else begin
            mem_r[0] <= mem_r[0];
        end
    end

    // Scoreboard: the mark is applied after the write-clear so it wins on a collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_r <= {DEPTH{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            busy_r[idx_r] <= 1'b0;
        end else begin
            if (wr_en_s) begin
                busy_r[bus.DR] <= 1'b0;
            end
            if (mark_en_s) begin
                busy_r[bus.Mark_addr] <= 1'b1;
            end
        end
    end

    assign bus.SR1_OUT    = read_port(bus.SR1);
    assign bus.SR2_OUT    = read_port(bus.SR2);
    assign bus.SR1_busy   = in_range(bus.SR1) ? busy_r[bus.SR1] : 1'b0;
    assign bus.SR2_busy   = in_range(bus.SR2) ? busy_r[bus.SR2] : 1'b0;
    assign bus.Clear_busy = clear_busy_r;
    assign bus.Clear_done = clear_done_r;
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench: DEPTH=8 and DEPTH=6 instances share one stimulus stream
// and are compared every cycle against a behavioural array model.
module tb_reg_file_param;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ld = 1'b0, mk = 1'b0, creq = 1'b0;
    logic [2:0]  dr = 3'd0, sr1 = 3'd0, sr2 = 3'd0, mka = 3'd0;
    logic [15:0] q = 16'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int nb8, nb6, nd8, nd6;

    // Model state, index 0 = DEPTH 8 instance, index 1 = DEPTH 6 instance.
    logic [15:0] m_mem  [2][8];
    bit          m_busy [2][8];
    bit          m_clr  [2];
    bit          m_done [2];
    int          m_idx  [2];
    int          depth  [2] = '{8, 6};

    reg_file_if #(.WIDTH(16), .DEPTH(8)) bus8 ();
    reg_file_if #(.WIDTH(16), .DEPTH(6)) bus6 ();

    assign bus8.Load = ld;   assign bus6.Load = ld;
    assign bus8.DR = dr;     assign bus6.DR = dr;
    assign bus8.Q = q;       assign bus6.Q = q;
    assign bus8.SR1 = sr1;   assign bus6.SR1 = sr1;
    assign bus8.SR2 = sr2;   assign bus6.SR2 = sr2;
    assign bus8.Mark = mk;   assign bus6.Mark = mk;
    assign bus8.Mark_addr = mka; assign bus6.Mark_addr = mka;
    assign bus8.Clear_req = creq; assign bus6.Clear_req = creq;

    reg_file_param #(.WIDTH(16), .DEPTH(8)) dut8 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus8.slave));
    reg_file_param #(.WIDTH(16), .DEPTH(6)) dut6 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus6.slave));

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int d, input logic [2:0] a);
        if (int'(a) >= depth[d]) return 16'd0;
        if (ld && dr == a && !m_clr[d]) return q;
        return m_mem[d][a];
    endfunction

    function automatic logic exp_busy(input int d, input logic [2:0] a);
        if (int'(a) >= depth[d]) return 1'b0;
        return m_busy[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[d][i]  = 16'd0;
                m_busy[d][i] = 1'b0;
            end
            m_clr[d] = 1'b0; m_done[d] = 1'b0; m_idx[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (m_clr[d]) begin
                m_mem[d][m_idx[d]]  = 16'd0;
                m_busy[d][m_idx[d]] = 1'b0;
                m_idx[d]++;
                if (m_idx[d] == depth[d]) begin
                    m_clr[d]  = 1'b0;
                    m_done[d] = 1'b1;
                end
            end else begin
                if (ld && int'(dr) < depth[d]) begin
                    m_mem[d][dr]  = q;
                    m_busy[d][dr] = 1'b0;
                end
                if (mk && int'(mka) < depth[d]) m_busy[d][mka] = 1'b1;
                if (m_done[d]) m_done[d] = 1'b0;
                else if (creq) begin
                    m_clr[d] = 1'b1;
                    m_idx[d] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("d8_sr1_out",  bus8.SR1_OUT,    exp_rd(0, sr1));
        check_eq("d8_sr2_out",  bus8.SR2_OUT,    exp_rd(0, sr2));
        check_eq("d8_sr1_busy", bus8.SR1_busy,   exp_busy(0, sr1));
        check_eq("d8_sr2_busy", bus8.SR2_busy,   exp_busy(0, sr2));
        check_eq("d8_clr_busy", bus8.Clear_busy, m_clr[0]);
        check_eq("d8_clr_done", bus8.Clear_done, m_done[0]);
        check_eq("d6_sr1_out",  bus6.SR1_OUT,    exp_rd(1, sr1));
        check_eq("d6_sr2_out",  bus6.SR2_OUT,    exp_rd(1, sr2));
        check_eq("d6_sr1_busy", bus6.SR1_busy,   exp_busy(1, sr1));
        check_eq("d6_sr2_busy", bus6.SR2_busy,   exp_busy(1, sr2));
        check_eq("d6_clr_busy", bus6.Clear_busy, m_clr[1]);
        check_eq("d6_clr_done", bus6.Clear_done, m_done[1]);
    endtask

    // Compare at the falling edge, advance the model at the rising edge, then leave room to drive.
    task automatic step();
        @(negedge Clk);
        compare_all();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        ld = 1'b0; mk = 1'b0; creq = 1'b0;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            ld = 1'b1; dr = 3'(i); q = 16'(i + 1);
            step();
        end
        ld = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        compare_all();
        @(posedge Clk); #1;

        // Bypass on a write, then stored value visible after the edge.
        ld = 1'b1; dr = 3'd3; q = 16'hBEEF; sr1 = 3'd3; sr2 = 3'd0;
        #1; check_eq("t1_bypass", bus8.SR1_OUT, 16'hBEEF);
        step();
        ld = 1'b0; sr1 = 3'd2; sr2 = 3'd3;
        #1; check_eq("t1_stored", bus8.SR2_OUT, 16'hBEEF);
        check_eq("t1_r2_zero", bus8.SR1_OUT, 16'h0000);
        step();

        // Scoreboard: mark, write clears, simultaneous mark+write keeps it set.
        mk = 1'b1; mka = 3'd5; step();
        mk = 1'b0; sr1 = 3'd5;
        #1; check_eq("t2_marked", bus8.SR1_busy, 1'b1);
        ld = 1'b1; dr = 3'd5; q = 16'h0055; step();
        ld = 1'b0;
        #1; check_eq("t2_cleared", bus8.SR1_busy, 1'b0);
        ld = 1'b1; mk = 1'b1; step();
        idle_inputs();
        #1; check_eq("t2_mark_wins", bus8.SR1_busy, 1'b1);

        // Clear sequence timing on both depths.
        fill();
        creq = 1'b1; step(); creq = 1'b0;
        sr1 = 3'd0; sr2 = 3'd7;
        nb8 = 0; nb6 = 0; nd8 = 0; nd6 = 0;
        for (int i = 0; i < 12; i++) begin
            nb8 += int'(bus8.Clear_busy); nb6 += int'(bus6.Clear_busy);
            nd8 += int'(bus8.Clear_done); nd6 += int'(bus6.Clear_done);
            if (i == 1) begin
                check_eq("t3_r0_cleared", bus8.SR1_OUT, 16'h0000);
                check_eq("t3_r7_kept", bus8.SR2_OUT, 16'h0008);
            end
            step();
        end
        check_eq("t3_busy_len8", nb8, 32'd8);
        check_eq("t6_busy_len6", nb6, 32'd6);
        check_eq("t3_done_pulse8", nd8, 32'd1);
        check_eq("t6_done_pulse6", nd6, 32'd1);

        // Writes and marks during a clear are dropped.
        fill();
        creq = 1'b1; step(); creq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld = 1'b1; dr = 3'd7; q = 16'h1234; mk = 1'b1; mka = 3'd2;
            step();
        end
        idle_inputs();
        repeat (10) step();
        sr1 = 3'd2; sr2 = 3'd7;
        #1; check_eq("t4_r7_dropped", bus8.SR2_OUT, 16'h0000);
        check_eq("t4_mark_dropped", bus8.SR1_busy, 1'b0);

        // Asynchronous reset in the middle of a clear.
        fill();
        creq = 1'b1; step(); creq = 1'b0;
        repeat (4) step();
        sr1 = 3'd6; sr2 = 3'd7;
        Reset_n = 1'b0;
        #2;
        model_reset();
        check_eq("t5_busy_abort", bus8.Clear_busy, 1'b0);
        check_eq("t5_r7_zero", bus8.SR2_OUT, 16'h0000);
        compare_all();
        Reset_n = 1'b1;
        repeat (3) step();

        // Out-of-range addresses on the DEPTH 6 instance.
        ld = 1'b1; dr = 3'd7; q = 16'hABCD; mk = 1'b1; mka = 3'd6;
        step();
        idle_inputs(); sr1 = 3'd6; sr2 = 3'd7;
        #1; check_eq("t6_sr6_zero", bus6.SR1_OUT, 16'h0000);
        check_eq("t6_sr6_busy", bus6.SR1_busy, 1'b0);
        check_eq("t6_sr7_zero", bus6.SR2_OUT, 16'h0000);
        check_eq("t6_d8_r7", bus8.SR2_OUT, 16'hABCD);
        step();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            ld   = 1'($urandom_range(0, 1));
            dr   = 3'($urandom_range(0, 7));
            q    = 16'($urandom);
            mk   = ($urandom_range(0, 2) == 0);
            mka  = 3'($urandom_range(0, 7));
            sr1  = 3'($urandom_range(0, 7));
            sr2  = 3'($urandom_range(0, 7));
            creq = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
